rv_fetch_unit: RTL

Instruction-fetch stage directly upstream of the next-PC generator. It holds the architectural PC register, presents it to `rv_nextpc_gen` and to instruction memory, and runs a single-outstanding request/response handshake with instruction memory. It buffers the returned instruction for decode with a valid/ready handshake. When decode retires the instruction, the PC is loaded from `nextpc`.

---
 rtl/my_pkg.sv | 17 +
 rtl/rv_pc_reg.sv | 24 ++
 rtl/rv_fetch_unit.sv | 106 ++++++++++
 3 files changed

// File: rtl/my_pkg.sv
// Shared definitions for the RV32 front end: datapath width, fetch FSM states
// and the default reset vector.
package my_pkg;

  localparam int DATA_WIDTH = 32;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_RESET,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_FAULT
  } fetch_state_t;

endpackage

// File: rtl/rv_pc_reg.sv
// Architectural PC register: asynchronous reset to the reset vector, loads
// only when the fetch stage retires an instruction with an aligned target.
module rv_pc_reg #(
  parameter int                WIDTH     = 32,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // NOTE: sequential state always uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_VAL;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// Instruction-fetch stage: single-outstanding imem request/response, one-entry
// instruction buffer toward decode, and sticky misalign/bus fault flags.
module rv_fetch_unit
  import my_pkg::*;
#(
  parameter int                    DATA_WIDTH = my_pkg::DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] nextpc,
  output logic [DATA_WIDTH-1:0] pc,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [DATA_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [DATA_WIDTH-1:0] imem_resp_data,
  input  logic                  imem_resp_err,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  output logic                  fault_misalign,
  output logic                  fault_bus
);

  fetch_state_t state;
  logic         aligned;
  logic         pc_load;

  assign aligned       = (nextpc[1:0] == 2'b00);
  assign pc_load       = (state == S_HOLD) && instr_ready && aligned;
  assign imem_req_addr = pc;

  rv_pc_reg #(
    .WIDTH     (DATA_WIDTH),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (nextpc),
    .q    (pc)
  );

  // Handshake valids are registered alongside the state so no input reaches
  // them combinationally; responses are only honoured in S_WAIT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= S_RESET;
      imem_req_valid <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= '0;
      instr_pc       <= '0;
      fault_misalign <= 1'b0;
      fault_bus      <= 1'b0;
    end else begin
      case (state)
        S_RESET: begin
          state          <= S_REQ;
          imem_req_valid <= 1'b1;
        end
        S_REQ: begin
          if (imem_req_ready) begin
            state          <= S_WAIT;
            imem_req_valid <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (imem_resp_err) begin
              fault_bus <= 1'b1;
              state     <= S_FAULT;
            end else begin
              instr       <= imem_resp_data;
              instr_pc    <= pc;
              instr_valid <= 1'b1;
              state       <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            instr_valid <= 1'b0;
            if (aligned) begin
              state          <= S_REQ;
              imem_req_valid <= 1'b1;
            end else begin
              fault_misalign <= 1'b1;
              state          <= S_FAULT;
            end
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state          <= S_FAULT;
          imem_req_valid <= 1'b0;
          instr_valid    <= 1'b0;
        end
      endcase
    end
  end

endmodule
